// File: rtl/alu_pkg.sv
// Shared opcodes, condition-code bit positions and FSM encodings for the execute-stage ALU.
package alu_pkg;
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_NOT  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_MOV  = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_SUB  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SETC = 4'd11;
    localparam logic [3:0] OP_CLRC = 4'd12;
    localparam logic [3:0] OP_PASS = 4'd13;
    localparam logic [3:0] OP_LDM  = 4'd14;
    localparam logic [3:0] OP_MUL  = 4'd15;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, WIDTH cycles after start.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               abort,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH:0]   sum;

    // Upper half accumulates while the multiplier drains out of the lower half.
    assign sum  = {1'b0, product[2*WIDTH-1:WIDTH]} + (product[0] ? {1'b0, mcand} : '0);
    assign done = busy && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            product <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            busy    <= 1'b1;
            cnt     <= CNT_W'(WIDTH - 1);
            mcand   <= a;
            product <= {{WIDTH{1'b0}}, b};
        end else if (busy) begin
            product <= {sum, product[WIDTH-1:1]};
            if (cnt == '0) busy <= 1'b0;
            else           cnt  <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with operand forwarding, CCR {C,N,Z} and a multi-cycle multiply.
// state | meaning
// IDLE  | accepting ops, single-cycle ops complete here
// MUL   | shift-add multiplier running
// DONE  | product final, written to result/CCR on exit
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int FWD_DEPTH = 2,
    parameter int RA_W      = 3,
    parameter int SHAMT_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                op,
    input  logic [RA_W-1:0]           src_addr,
    input  logic [RA_W-1:0]           dst_addr,
    input  logic [WIDTH-1:0]          src_data,
    input  logic [WIDTH-1:0]          dst_data,
    input  logic [WIDTH-1:0]          imm,
    input  logic [FWD_DEPTH-1:0]      fwd_wb,
    input  logic [FWD_DEPTH*RA_W-1:0] fwd_rd,
    input  logic [FWD_DEPTH*WIDTH-1:0] fwd_data,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          result,
    output logic [2:0]                flags
);
    state_t               state;
    logic                 accept;
    logic [WIDTH-1:0]     opa, opb;
    logic [FWD_DEPTH-1:0] hit_a, hit_b;
    logic [WIDTH-1:0]     fdata [FWD_DEPTH];
    logic [SHAMT_W-1:0]   shamt;
    logic [WIDTH:0]       sh_l, sh_r, add_ext, inc_ext;
    logic [WIDTH-1:0]     alu_res;
    logic                 c_new, upd_zn, upd_c;
    logic                 mul_busy, mul_done;
    logic [2*WIDTH-1:0]   product;

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready && !flush;

    for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_fwd
        assign fdata[k] = fwd_data[k*WIDTH +: WIDTH];
        assign hit_a[k] = fwd_wb[k] && (fwd_rd[k*RA_W +: RA_W] == src_addr);
        assign hit_b[k] = fwd_wb[k] && (fwd_rd[k*RA_W +: RA_W] == dst_addr);
    end

    // Walk oldest to youngest so the lowest matching k has the final say.
    always_comb begin
        opa = src_data;
        opb = dst_data;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (hit_a[k]) opa = fdata[k];
            if (hit_b[k]) opb = fdata[k];
        end
    end

    assign shamt   = imm[SHAMT_W-1:0];
    assign sh_l    = {1'b0, opa} << shamt;
    assign sh_r    = {opa, 1'b0} >> shamt;
    assign add_ext = {1'b0, opa} + {1'b0, opb};
    assign inc_ext = {1'b0, opa} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res = result;
        c_new   = flags[FLG_C];
        upd_zn  = 1'b0;
        upd_c   = 1'b0;
        case (op)
            OP_NOT:  begin alu_res = ~opa;                c_new = 1'b0;        upd_zn = 1'b1; upd_c = 1'b1; end
            OP_INC:  begin alu_res = inc_ext[WIDTH-1:0];  c_new = inc_ext[WIDTH]; upd_zn = 1'b1; upd_c = 1'b1; end
            OP_DEC:  begin alu_res = opa - WIDTH'(1);     c_new = (opa == '0);  upd_zn = 1'b1; upd_c = 1'b1; end
            OP_MOV:  alu_res = opb;
            OP_ADD:  begin alu_res = add_ext[WIDTH-1:0];  c_new = add_ext[WIDTH]; upd_zn = 1'b1; upd_c = 1'b1; end
            OP_SUB:  begin alu_res = opa - opb;           c_new = (opa < opb);  upd_zn = 1'b1; upd_c = 1'b1; end
            OP_AND:  begin alu_res = opa & opb;           upd_zn = 1'b1; end
            OP_OR:   begin alu_res = opa | opb;           upd_zn = 1'b1; end
            OP_SHL:  begin alu_res = sh_l[WIDTH-1:0];     c_new = sh_l[WIDTH];  upd_zn = 1'b1; upd_c = (shamt != '0); end
            OP_SHR:  begin alu_res = sh_r[WIDTH:1];       c_new = sh_r[0];      upd_zn = 1'b1; upd_c = (shamt != '0); end
            OP_SETC: begin c_new = 1'b1; upd_c = 1'b1; end
            OP_CLRC: begin c_new = 1'b0; upd_c = 1'b1; end
            OP_PASS: alu_res = opa;
            OP_LDM:  alu_res = imm;
            default: ;
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .abort   (flush),
        .start   (accept && (op == OP_MUL)),
        .a       (opa),
        .b       (opb),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            result    <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (in_valid && op == OP_MUL) begin
                            state <= ST_MUL;
                        end else if (in_valid && op != OP_NOP) begin
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            if (upd_zn) begin
                                flags[FLG_Z] <= (alu_res == '0);
                                flags[FLG_N] <= alu_res[WIDTH-1];
                            end
                            if (upd_c) flags[FLG_C] <= c_new;
                        end
                    end
                    ST_MUL: begin
                        if (mul_done || !mul_busy) state <= ST_DONE;
                    end
                    ST_DONE: begin
                        result       <= product[WIDTH-1:0];
                        flags[FLG_C] <= |product[2*WIDTH-1:WIDTH];
                        flags[FLG_N] <= product[WIDTH-1];
                        flags[FLG_Z] <= (product[WIDTH-1:0] == '0);
                        out_valid    <= 1'b1;
                        state        <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: expected results queued at issue, checked when out_valid fires.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int WIDTH     = 16;
    localparam int FWD_DEPTH = 2;
    localparam int RA_W      = 3;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       flush = 1'b0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic [3:0]                 op = '0;
    logic [RA_W-1:0]            src_addr = '0, dst_addr = '0;
    logic [WIDTH-1:0]           src_data = '0, dst_data = '0, imm = '0;
    logic [FWD_DEPTH-1:0]       fwd_wb = '0;
    logic [FWD_DEPTH*RA_W-1:0]  fwd_rd = '0;
    logic [FWD_DEPTH*WIDTH-1:0] fwd_data = '0;
    logic                       out_valid;
    logic [WIDTH-1:0]           result;
    logic [2:0]                 flags;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [2:0]       flg;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               checks = 0, passed = 0, fails = 0;
    logic [WIDTH-1:0] exp_res = '0;
    logic [2:0]       exp_flg = '0;
    int               low;
    logic [WIDTH-1:0] ra, rb;
    logic [31:0]      pr;

    alu_exec_unit #(.WIDTH(WIDTH), .FWD_DEPTH(FWD_DEPTH), .RA_W(RA_W), .SHAMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_addr(src_addr), .dst_addr(dst_addr), .src_data(src_data),
        .dst_data(dst_data), .imm(imm), .fwd_wb(fwd_wb), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input logic [WIDTH-1:0] r, input logic [2:0] f);
        sb.push_back(exp_t'{res: r, flg: f});
        exp_res = r;
        exp_flg = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] o, input logic [RA_W-1:0] sa, input logic [RA_W-1:0] da,
                         input logic [WIDTH-1:0] sd, input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] im);
        op = o; src_addr = sa; dst_addr = da; src_data = sd; dst_data = dd; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [RA_W-1:0] sa, input logic [RA_W-1:0] da,
                         input logic [WIDTH-1:0] sd, input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] im);
        drive(o, sa, da, sd, dd, im);
        chk($sformatf("in_ready_before_op%0d", o), 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        chk("wait_ready_bound", 32'(in_ready), 32'd1);
    endtask

    // Scoreboard side: every out_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_result", 32'(result), 32'(mon_e.res));
                chk("sb_flags", 32'(flags), 32'(mon_e.flg));
            end
        end
    end

    initial begin
        #1;
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADD with wrap: carry out, zero result
        expect_out(16'h0000, 3'b101);
        issue(OP_ADD, 3'd1, 3'd2, 16'hFFFF, 16'h0001, 16'h0);
        chk("add_out_valid", 32'(out_valid), 32'd1);
        tick();
        chk("add_pulse_one_cycle", 32'(out_valid), 32'd0);

        // SUB: both forwarding sources hit r1, youngest (k=0) must win
        fwd_wb   = 2'b11;
        fwd_rd   = {3'd1, 3'd1};
        fwd_data = {16'd9, 16'd3};
        expect_out(16'hFFFE, 3'b110);
        issue(OP_SUB, 3'd1, 3'd2, 16'h7777, 16'd5, 16'h0);
        // only k=1 hits
        fwd_wb = 2'b10;
        expect_out(16'h0009, 3'b110);
        issue(OP_PASS, 3'd1, 3'd2, 16'h7777, 16'd5, 16'h0);
        fwd_wb = 2'b00;

        // Shifts, MOV holding CCR, carry-only ops, back-to-back
        expect_out(16'h0002, 3'b100);
        issue(OP_SHL, 3'd3, 3'd4, 16'h8001, 16'h0, 16'd1);
        expect_out(16'h0000, 3'b100);
        issue(OP_MOV, 3'd3, 3'd4, 16'h1111, 16'h0000, 16'h0);
        expect_out(16'h0001, 3'b100);
        issue(OP_SHR, 3'd3, 3'd4, 16'h0003, 16'h0, 16'd1);
        expect_out(16'h0000, 3'b101);
        issue(OP_SHL, 3'd3, 3'd4, 16'h0000, 16'h0, 16'h0010);
        expect_out(16'h0000, 3'b001);
        issue(OP_CLRC, 3'd3, 3'd4, 16'hAAAA, 16'h5555, 16'h0);
        expect_out(16'hFFFF, 3'b110);
        issue(OP_DEC, 3'd3, 3'd4, 16'h0000, 16'h0, 16'h0);
        expect_out(16'h0000, 3'b101);
        issue(OP_INC, 3'd3, 3'd4, 16'hFFFF, 16'h0, 16'h0);
        expect_out(16'h0000, 3'b101);
        issue(OP_AND, 3'd3, 3'd4, 16'hF0F0, 16'h0F0F, 16'h0);
        expect_out(16'h0000, 3'b001);
        issue(OP_NOT, 3'd3, 3'd4, 16'hFFFF, 16'h0, 16'h0);
        expect_out(16'h8001, 3'b010);
        issue(OP_OR, 3'd3, 3'd4, 16'h8000, 16'h0001, 16'h0);
        expect_out(16'h8001, 3'b110);
        issue(OP_SETC, 3'd3, 3'd4, 16'h1234, 16'h5678, 16'h0);
        expect_out(16'h1234, 3'b110);
        issue(OP_LDM, 3'd3, 3'd4, 16'h0, 16'h0, 16'h1234);
        issue(OP_NOP, 3'd3, 3'd4, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        chk("nop_no_out_valid", 32'(out_valid), 32'd0);
        chk("nop_result_held", 32'(result), 32'(exp_res));

        // MUL 0x0100*0x0100, next op held pending until the unit frees up
        expect_out(16'h0000, 3'b101);
        issue(OP_MUL, 3'd1, 3'd2, 16'h0100, 16'h0100, 16'h0);
        drive(OP_LDM, 3'd0, 3'd0, 16'h0, 16'h0, 16'h4321);
        low = 0;
        while (!in_ready && low < 100) begin
            low++;
            tick();
        end
        chk("mul_ready_low_cycles", 32'(low), 32'd17);
        chk("mul_out_valid_at_ready", 32'(out_valid), 32'd1);
        expect_out(16'h4321, 3'b101);
        tick();
        in_valid = 1'b0;
        chk("op_after_mul_out_valid", 32'(out_valid), 32'd1);

        expect_out(16'h02FD, 3'b000);
        issue(OP_MUL, 3'd1, 3'd2, 16'h00FF, 16'h0003, 16'h0);
        wait_ready();
        tick();

        ra = 16'($urandom_range(0, 65535));
        rb = 16'($urandom_range(0, 65535));
        pr = 32'(ra) * 32'(rb);
        expect_out(pr[15:0], {(pr[31:16] != 16'h0), pr[15], (pr[15:0] == 16'h0)});
        issue(OP_MUL, 3'd1, 3'd2, ra, rb, 16'h0);
        wait_ready();
        tick();

        // Flush in IDLE drops the offered op
        flush = 1'b1;
        drive(OP_LDM, 3'd0, 3'd0, 16'h0, 16'h0, 16'hBEEF);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle_no_valid", 32'(out_valid), 32'd0);
        chk("flush_idle_result", 32'(result), 32'(exp_res));

        // Flush mid-MUL at cycle 5
        issue(OP_MUL, 3'd1, 3'd2, 16'h0003, 16'h0005, 16'h0);
        repeat (4) tick();
        flush = 1'b1;
        drive(OP_LDM, 3'd0, 3'd0, 16'h0, 16'h0, 16'hBEEF);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_mul_in_ready", 32'(in_ready), 32'd1);
        chk("flush_mul_result", 32'(result), 32'(exp_res));
        chk("flush_mul_flags", 32'(flags), 32'(exp_flg));
        repeat (25) tick();
        chk("flush_mul_no_valid", 32'(out_valid), 32'd0);
        chk("flush_mul_sb_empty", 32'(sb.size()), 32'd0);

        // Async reset mid-MUL with a nonzero CCR/result beforehand
        expect_out(exp_res, {1'b1, exp_flg[1:0]});
        issue(OP_SETC, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
        tick();
        issue(OP_MUL, 3'd1, 3'd2, 16'h0007, 16'h0009, 16'h0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mul_result", 32'(result), 32'd0);
        chk("rst_mid_mul_flags", 32'(flags), 32'd0);
        chk("rst_mid_mul_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_mul_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_result", 32'(result), 32'd0);
        chk("post_rst_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
